// File: rtl/ram_arbiter_pkg.sv
// Shared definitions for the 8-bit system RAM path: requester IDs,
// default RAM geometry and the arbiter lock-state encoding.
package ram_arbiter_pkg;

  // Default RAM geometry, shared with the RAM modules
  localparam int RAM_ADDR_W = 10;
  localparam int RAM_DATA_W = 8;

  // Requester identifiers
  localparam logic REQ_A = 1'b0;
  localparam logic REQ_B = 1'b1;

  // Lock ownership state (only used when RAM_ARB_LOCK_EN is defined)
  typedef enum logic {
    LOCK_FREE = 1'b0,
    LOCK_HELD = 1'b1
  } lock_state_t;

endpackage

// File: rtl/ram_arbiter_rr_arb2.sv
// rr_arb2: two-way round-robin grant generator.
// Holds the priority pointer and, when RAM_ARB_LOCK_EN is defined, a
// FREE/LOCKED ownership FSM that lets one requester keep the RAM for an
// atomic read-modify-write sequence.
// Grants are combinational and forced low while rst_n is asserted.
module rr_arb2
  import ram_arbiter_pkg::*;
(
  input  logic clk,
  input  logic rst_n,
  input  logic req_a,
  input  logic req_b,
`ifdef RAM_ARB_LOCK_EN
  input  logic lock_a,
  input  logic lock_b,
`endif
  output logic gnt_a,
  output logic gnt_b
);

  logic prio_r;          // REQ_A: A preferred, REQ_B: B preferred
  logic lock_hold_s;     // a lock owner is present and still requesting
  logic lock_owner_s;    // which requester holds the lock
  logic granted_lock_s;  // the access granted this cycle carries lock = 1
  logic gnt_any_s;

  assign gnt_any_s = gnt_a | gnt_b;

`ifdef RAM_ARB_LOCK_EN
  lock_state_t state_r;
  lock_state_t state_nxt;
  logic        owner_r;
  logic        owner_nxt;

  assign lock_owner_s = owner_r;

  // Lock is only effective while its owner keeps requesting; dropping req frees it
  always_comb begin
    lock_hold_s = 1'b0;
    if (state_r == LOCK_HELD) begin
      lock_hold_s = (owner_r == REQ_A) ? req_a : req_b;
    end else begin
      lock_hold_s = 1'b0;
    end
  end

  // Lock flag of whichever requester is granted this cycle
  always_comb begin
    granted_lock_s = 1'b0;
    if (gnt_a) begin
      granted_lock_s = lock_a;
    end else if (gnt_b) begin
      granted_lock_s = lock_b;
    end else begin
      granted_lock_s = 1'b0;
    end
  end

  // Lock FSM next state: a locked grant claims ownership, anything else releases it
  always_comb begin
    state_nxt = state_r;
    owner_nxt = owner_r;
    case (state_r)
      LOCK_FREE: begin
        if (gnt_any_s && granted_lock_s) begin
          state_nxt = LOCK_HELD;
          owner_nxt = gnt_b ? REQ_B : REQ_A;
        end else begin
          state_nxt = LOCK_FREE;
        end
      end
      LOCK_HELD: begin
        if (gnt_any_s && granted_lock_s) begin
          state_nxt = LOCK_HELD;
          owner_nxt = gnt_b ? REQ_B : REQ_A;
        end else if (gnt_any_s || !lock_hold_s) begin
          state_nxt = LOCK_FREE;
        end else begin
          state_nxt = LOCK_HELD;
        end
      end
      default: begin
        state_nxt = LOCK_FREE;
        owner_nxt = REQ_A;
      end
    endcase
  end

  // Lock FSM state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= LOCK_FREE;
      owner_r <= REQ_A;
    end else begin
      state_r <= state_nxt;
      owner_r <= owner_nxt;
    end
  end
`else
  assign lock_hold_s    = 1'b0;
  assign lock_owner_s   = REQ_A;
  assign granted_lock_s = 1'b0;
`endif

  // Grant selection: lock owner first, then sole requester, then priority pointer
  always_comb begin
    gnt_a = 1'b0;
    gnt_b = 1'b0;
    if (!rst_n) begin
      gnt_a = 1'b0;
      gnt_b = 1'b0;
    end else if (lock_hold_s) begin
      gnt_a = (lock_owner_s == REQ_A);
      gnt_b = (lock_owner_s == REQ_B);
    end else if (req_a && req_b) begin
      gnt_a = (prio_r == REQ_A);
      gnt_b = (prio_r == REQ_B);
    end else if (req_a) begin
      gnt_a = 1'b1;
    end else if (req_b) begin
      gnt_b = 1'b1;
    end else begin
      gnt_a = 1'b0;
      gnt_b = 1'b0;
    end
  end

  // Priority rotates to the loser after every unlocked grant; locked grants freeze it
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prio_r <= REQ_A;
    end else if (gnt_any_s && !granted_lock_s) begin
      prio_r <= gnt_a ? REQ_B : REQ_A;
    end else begin
      prio_r <= prio_r;
    end
  end

endmodule

// File: rtl/ram_arbiter.sv
// ram_arbiter: shares one single-port synchronous RAM (1-cycle registered
// read) between requesters A and B. One access per cycle, round-robin
// arbitration via rr_arb2, read data returned to the issuing requester
// one cycle after its grant.
// Optional macro RAM_ARB_LOCK_EN adds a_lock/b_lock for atomic sequences.
module ram_arbiter
  import ram_arbiter_pkg::*;
#(
  parameter int A = RAM_ADDR_W,
  parameter int D = RAM_DATA_W
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         a_req,
  input  logic         a_we,
  input  logic [A-1:0] a_addr,
  input  logic [D-1:0] a_wdata,
`ifdef RAM_ARB_LOCK_EN
  input  logic         a_lock,
`endif
  output logic         a_gnt,
  output logic         a_rvalid,
  output logic [D-1:0] a_rdata,
  input  logic         b_req,
  input  logic         b_we,
  input  logic [A-1:0] b_addr,
  input  logic [D-1:0] b_wdata,
`ifdef RAM_ARB_LOCK_EN
  input  logic         b_lock,
`endif
  output logic         b_gnt,
  output logic         b_rvalid,
  output logic [D-1:0] b_rdata,
  output logic [A-1:0] ram_addr,
  output logic [D-1:0] ram_din,
  output logic         ram_we,
  input  logic [D-1:0] ram_dout
);

  logic         gnt_a_s;
  logic         gnt_b_s;
  logic         gnt_any_s;
  logic [A-1:0] addr_hold_r;  // last granted address, driven when idle
  logic [D-1:0] din_hold_r;   // last granted write data, driven when idle
  logic         rd_pend_r;    // a read was issued last cycle
  logic         rd_owner_r;   // requester that issued that read

  rr_arb2 u_rr_arb2 (
    .clk    (clk),
    .rst_n  (rst_n),
    .req_a  (a_req),
    .req_b  (b_req),
`ifdef RAM_ARB_LOCK_EN
    .lock_a (a_lock),
    .lock_b (b_lock),
`endif
    .gnt_a  (gnt_a_s),
    .gnt_b  (gnt_b_s)
  );

  assign a_gnt     = gnt_a_s;
  assign b_gnt     = gnt_b_s;
  assign gnt_any_s = gnt_a_s | gnt_b_s;

  // RAM port mux: granted requester drives the RAM, idle cycles hold the bus steady
  always_comb begin
    ram_addr = addr_hold_r;
    ram_din  = din_hold_r;
    ram_we   = 1'b0;
    if (gnt_b_s) begin
      ram_addr = b_addr;
      ram_din  = b_wdata;
      ram_we   = b_we;
    end else if (gnt_a_s) begin
      ram_addr = a_addr;
      ram_din  = a_wdata;
      ram_we   = a_we;
    end else begin
      ram_addr = addr_hold_r;
      ram_din  = din_hold_r;
      ram_we   = 1'b0;
    end
  end

  // Capture the granted address/data so the RAM bus does not toggle when idle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr_hold_r <= {A{1'b0}};
      din_hold_r  <= {D{1'b0}};
    end else if (gnt_any_s) begin
      addr_hold_r <= ram_addr;
      din_hold_r  <= ram_din;
    end else begin
      addr_hold_r <= addr_hold_r;
      din_hold_r  <= din_hold_r;
    end
  end

  // Read-return pipeline: remember who issued a read so the RAM output reaches them
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_pend_r  <= 1'b0;
      rd_owner_r <= REQ_A;
    end else if (gnt_any_s) begin
      rd_pend_r  <= ~ram_we;
      rd_owner_r <= gnt_b_s ? REQ_B : REQ_A;
    end else begin
      rd_pend_r  <= 1'b0;
      rd_owner_r <= rd_owner_r;
    end
  end

  // Both requesters see the RAM output; only the owner's rvalid qualifies it
  assign a_rvalid = rd_pend_r & (rd_owner_r == REQ_A);
  assign b_rvalid = rd_pend_r & (rd_owner_r == REQ_B);
  assign a_rdata  = ram_dout;
  assign b_rdata  = ram_dout;

endmodule

// File: tb/tb_ram_arbiter.sv
// Self-checking bench for ram_arbiter with a behavioural single-port RAM
// and a read-return scoreboard. Define RAM_ARB_LOCK_EN to exercise locking.
module tb_ram_arbiter;

  localparam logic OWN_A = 1'b0;
  localparam logic OWN_B = 1'b1;

  typedef struct {
    int         cyc;
    logic       owner;
    logic [7:0] data;
  } sb_item_t;

  logic       clk;
  logic       rst_n;
  logic       a_req, a_we, b_req, b_we;
  logic [9:0] a_addr, b_addr;
  logic [7:0] a_wdata, b_wdata;
  logic       a_gnt, a_rvalid, b_gnt, b_rvalid;
  logic [7:0] a_rdata, b_rdata;
  logic [9:0] ram_addr;
  logic [7:0] ram_din;
  logic       ram_we;
  logic [7:0] ram_dout;
`ifdef RAM_ARB_LOCK_EN
  logic       a_lock, b_lock;
`endif

  logic [7:0] mem [0:1023];
  int         cyc;
  int         n_tests;
  int         n_fail;
  sb_item_t   sb_q[$];

  ram_arbiter dut (
    .clk(clk), .rst_n(rst_n),
    .a_req(a_req), .a_we(a_we), .a_addr(a_addr), .a_wdata(a_wdata),
`ifdef RAM_ARB_LOCK_EN
    .a_lock(a_lock),
`endif
    .a_gnt(a_gnt), .a_rvalid(a_rvalid), .a_rdata(a_rdata),
    .b_req(b_req), .b_we(b_we), .b_addr(b_addr), .b_wdata(b_wdata),
`ifdef RAM_ARB_LOCK_EN
    .b_lock(b_lock),
`endif
    .b_gnt(b_gnt), .b_rvalid(b_rvalid), .b_rdata(b_rdata),
    .ram_addr(ram_addr), .ram_din(ram_din), .ram_we(ram_we), .ram_dout(ram_dout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural RAM: registered read, old data on write
  always @(posedge clk) begin
    if (ram_we) mem[ram_addr] <= ram_din;
    ram_dout <= mem[ram_addr];
  end

  always @(posedge clk) cyc <= cyc + 1;

  task automatic idle();
    a_req = 1'b0; a_we = 1'b0; b_req = 1'b0; b_we = 1'b0;
`ifdef RAM_ARB_LOCK_EN
    a_lock = 1'b0; b_lock = 1'b0;
`endif
  endtask

  task automatic push_exp(input logic owner, input logic [7:0] data);
    sb_item_t e;
    e.cyc = cyc + 1; e.owner = owner; e.data = data;
    sb_q.push_back(e);
  endtask

  // Pops an expectation whenever an rvalid shows up, flags late/missing/extra ones
  task automatic scoreboard_monitor();
    sb_item_t e;
    logic [7:0] got;
    forever begin
      @(negedge clk);
      if (a_rvalid === 1'b1 || b_rvalid === 1'b1) begin
        n_tests++;
        if (sb_q.size() == 0) begin
          n_fail++;
          $display("FAIL sb_unexpected: cyc %0d a_rvalid=%b b_rvalid=%b, wanted none", cyc, a_rvalid, b_rvalid);
        end else begin
          e = sb_q.pop_front();
          got = (e.owner == OWN_A) ? a_rdata : b_rdata;
          if (cyc !== e.cyc || a_rvalid !== (e.owner == OWN_A) || b_rvalid !== (e.owner == OWN_B) || got !== e.data) begin
            n_fail++;
            $display("FAIL sb_rdata: cyc %0d a_rvalid=%b b_rvalid=%b data=%h, wanted cyc %0d owner %b data %h",
                     cyc, a_rvalid, b_rvalid, got, e.cyc, e.owner, e.data);
          end
        end
      end else if (sb_q.size() > 0 && sb_q[0].cyc <= cyc) begin
        n_tests++; n_fail++;
        e = sb_q.pop_front();
        $display("FAIL sb_missing: cyc %0d no rvalid, wanted owner %b data %h", cyc, e.owner, e.data);
      end
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; idle(); a_req = 1'b1; b_req = 1'b1; a_we = 1'b1; b_we = 1'b1;
    a_addr = 10'h000; b_addr = 10'h000; a_wdata = 8'h00; b_wdata = 8'h00;
    @(negedge clk);
    n_tests++; if (a_gnt !== 1'b0 || b_gnt !== 1'b0) begin n_fail++; $display("FAIL reset_gnt: got a=%b b=%b want 0 0", a_gnt, b_gnt); end
    n_tests++; if (ram_we !== 1'b0) begin n_fail++; $display("FAIL reset_ram_we: got %b want 0", ram_we); end
    n_tests++; if (a_rvalid !== 1'b0 || b_rvalid !== 1'b0) begin n_fail++; $display("FAIL reset_rvalid: got a=%b b=%b want 0 0", a_rvalid, b_rvalid); end
    @(posedge clk); #1;
    idle(); rst_n = 1'b1;
  endtask

  task automatic test_write();
    @(posedge clk); #1;
    a_req = 1'b1; a_we = 1'b1; a_addr = 10'h010; a_wdata = 8'h5A;
    @(negedge clk);
    n_tests++; if (a_gnt !== 1'b1 || b_gnt !== 1'b0) begin n_fail++; $display("FAIL write_gnt: got a=%b b=%b want 1 0", a_gnt, b_gnt); end
    n_tests++; if (ram_we !== 1'b1 || ram_addr !== 10'h010 || ram_din !== 8'h5A) begin
      n_fail++; $display("FAIL write_ram: got we=%b addr=%h din=%h want 1 010 5a", ram_we, ram_addr, ram_din); end
    @(posedge clk); #1;
    idle(); a_addr = 10'h3FF;
    @(negedge clk);
    n_tests++; if (a_rvalid !== 1'b0) begin n_fail++; $display("FAIL write_no_rvalid: got %b want 0", a_rvalid); end
    n_tests++; if (ram_addr !== 10'h010 || ram_we !== 1'b0) begin
      n_fail++; $display("FAIL idle_hold: got addr=%h we=%b want 010 0", ram_addr, ram_we); end
  endtask

  task automatic test_read();
    @(posedge clk); #1;
    a_req = 1'b1; a_we = 1'b0; a_addr = 10'h010;
    @(negedge clk);
    n_tests++; if (a_gnt !== 1'b1 || ram_we !== 1'b0) begin n_fail++; $display("FAIL read_gnt: got gnt=%b we=%b want 1 0", a_gnt, ram_we); end
    push_exp(OWN_A, 8'h5A);
    @(posedge clk); #1;
    idle();
    @(negedge clk);
    n_tests++; if (a_rvalid !== 1'b1 || b_rvalid !== 1'b0) begin
      n_fail++; $display("FAIL read_rvalid: got a=%b b=%b want 1 0", a_rvalid, b_rvalid); end
  endtask

  task automatic test_back_to_back();
    logic exp_b;
    @(posedge clk); #1;
    a_req = 1'b1; a_we = 1'b1; a_addr = 10'h001; a_wdata = 8'h11;
    @(posedge clk); #1;
    idle(); b_req = 1'b1; b_we = 1'b1; b_addr = 10'h002; b_wdata = 8'h22;
    @(posedge clk); #1;
    idle(); rst_n = 1'b0; #2; rst_n = 1'b1;
    a_req = 1'b1; a_we = 1'b0; a_addr = 10'h001;
    b_req = 1'b1; b_we = 1'b0; b_addr = 10'h002;
    for (int i = 0; i < 6; i++) begin
      exp_b = (i % 2 == 1) ? 1'b1 : 1'b0;
      @(negedge clk);
      n_tests++; if (a_gnt !== ~exp_b || b_gnt !== exp_b) begin
        n_fail++; $display("FAIL b2b_gnt[%0d]: got a=%b b=%b want a=%b b=%b", i, a_gnt, b_gnt, ~exp_b, exp_b); end
      push_exp(exp_b, exp_b ? 8'h22 : 8'h11);
      @(posedge clk); #1;
    end
    idle();
    @(posedge clk); #1;
  endtask

  task automatic test_write_read();
    @(posedge clk); #1;
    b_req = 1'b1; b_we = 1'b1; b_addr = 10'h002; b_wdata = 8'h33;
    @(negedge clk);
    n_tests++; if (b_gnt !== 1'b1 || ram_we !== 1'b1) begin n_fail++; $display("FAIL wr_b_gnt: got gnt=%b we=%b want 1 1", b_gnt, ram_we); end
    @(posedge clk); #1;
    idle(); a_req = 1'b1; a_we = 1'b0; a_addr = 10'h002;
    @(negedge clk);
    n_tests++; if (a_gnt !== 1'b1) begin n_fail++; $display("FAIL rd_a_gnt: got %b want 1", a_gnt); end
    push_exp(OWN_A, 8'h33);
    @(posedge clk); #1;
    idle();
    @(posedge clk); #1;
  endtask

  task automatic test_reset_mid_read();
    @(posedge clk); #1;
    b_req = 1'b1; b_we = 1'b0; b_addr = 10'h001;
    @(negedge clk);
    n_tests++; if (b_gnt !== 1'b1) begin n_fail++; $display("FAIL mid_b_gnt: got %b want 1", b_gnt); end
    @(posedge clk); #1;
    idle();
    n_tests++; if (b_rvalid !== 1'b1) begin n_fail++; $display("FAIL mid_pre_rvalid: got %b want 1", b_rvalid); end
    #1; rst_n = 1'b0; #1;
    n_tests++; if (b_rvalid !== 1'b0) begin n_fail++; $display("FAIL mid_drop_rvalid: got %b want 0", b_rvalid); end
    @(posedge clk); #1;
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      n_tests++; if (b_rvalid !== 1'b0 || a_rvalid !== 1'b0) begin
        n_fail++; $display("FAIL post_reset_rvalid[%0d]: got a=%b b=%b want 0 0", i, a_rvalid, b_rvalid); end
    end
  endtask

`ifdef RAM_ARB_LOCK_EN
  task automatic test_lock();
    @(posedge clk); #1;
    idle(); b_req = 1'b1; b_we = 1'b1; b_addr = 10'h003; b_wdata = 8'h44;
    @(posedge clk); #1;
    idle();
    a_req = 1'b1; a_we = 1'b0; a_addr = 10'h003; a_lock = 1'b1;
    b_req = 1'b1; b_we = 1'b0; b_addr = 10'h001;
    @(negedge clk);
    n_tests++; if (a_gnt !== 1'b1 || b_gnt !== 1'b0) begin n_fail++; $display("FAIL lock_rd_gnt: got a=%b b=%b want 1 0", a_gnt, b_gnt); end
    push_exp(OWN_A, 8'h44);
    @(posedge clk); #1;
    a_we = 1'b1; a_wdata = 8'h77; a_lock = 1'b0;
    @(negedge clk);
    n_tests++; if (a_gnt !== 1'b1 || b_gnt !== 1'b0 || ram_we !== 1'b1) begin
      n_fail++; $display("FAIL lock_wr_gnt: got a=%b b=%b we=%b want 1 0 1", a_gnt, b_gnt, ram_we); end
    @(posedge clk); #1;
    a_we = 1'b0;
    @(negedge clk);
    n_tests++; if (a_gnt !== 1'b0 || b_gnt !== 1'b1) begin n_fail++; $display("FAIL unlock_b_gnt: got a=%b b=%b want 0 1", a_gnt, b_gnt); end
    push_exp(OWN_B, 8'h11);
    @(posedge clk); #1;
    b_req = 1'b0;
    @(negedge clk);
    n_tests++; if (a_gnt !== 1'b1) begin n_fail++; $display("FAIL lock_rmw_result_gnt: got %b want 1", a_gnt); end
    push_exp(OWN_A, 8'h77);
    @(posedge clk); #1;
    idle();
    @(posedge clk); #1;
  endtask
`endif

  initial begin
    n_tests = 0; n_fail = 0; cyc = 0;
    fork
      scoreboard_monitor();
    join_none
    test_reset();
    test_write();
    test_read();
    test_back_to_back();
    test_write_read();
    test_reset_mid_read();
`ifdef RAM_ARB_LOCK_EN
    test_lock();
`endif
    repeat (3) @(posedge clk);
    #1;
    n_tests++; if (sb_q.size() != 0) begin n_fail++; $display("FAIL sb_drain: got %0d pending want 0", sb_q.size()); end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
